uio_stream_tx: RTL and testbench

- Byte-stream transmitter that pushes bytes from the user design out over the 8-bit uio pin bank to an external reader (host or cocotb bench).
- Uses a four-phase strobe/acknowledge handshake.
- Internal FIFO decouples the producer from the slow off-chip handshake.
- Drives uio_out/uio_oe and one uo_out bit (strobe); samples one ui_in bit (ack) through a synchronizer.

---
 rtl/uio_stream_tx.sv | 141 ++++++++++++++
 tb/tb_uio_stream_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_stream_tx.sv
// Byte-stream transmitter over the uio pin bank: a small FIFO feeds a
// four-phase strobe/acknowledge sequencer with setup delay and ack timeout.
//
// state   | meaning
// IDLE    | pins released; pops the FIFO head when one is available
// SETUP   | data/oe driven, counting down before strobe rises
// WAIT_HI | strobe high, waiting for synchronized ack to rise
// WAIT_LO | strobe low, waiting for synchronized ack to fall
`timescale 1ns/1ps
module uio_stream_tx #(
   parameter int DEPTH        = 4,
   parameter int SETUP_CYCLES = 2,
   parameter int TIMEOUT      = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_valid,
   input  logic [7:0]                 wr_data,
   output logic                       wr_ready,
   output logic [7:0]                 tx_data,
   output logic [7:0]                 tx_oe,
   output logic                       tx_stb,
   input  logic                       tx_ack,
   output logic                       busy,
   output logic                       timeout_err,
   input  logic                       err_clr,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] SETUP   = 2'd1;
   localparam logic [1:0] WAIT_HI = 2'd2;
   localparam logic [1:0] WAIT_LO = 2'd3;

   localparam logic [15:0] SETUP_LD = 16'(SETUP_CYCLES);
   localparam logic [15:0] TMO_LD   = 16'(TIMEOUT);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [1:0]    state;
   logic [15:0]   cnt;
   logic          ack_s1;
   logic          ack_s2;
   logic          push;
   logic          pop;

   assign wr_ready = (level != LW'(DEPTH));
   assign push     = wr_valid && wr_ready;
   assign pop      = (state == IDLE) && (level != '0);
   assign busy     = (state != IDLE) || (level != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         state       <= IDLE;
         cnt         <= '0;
         ack_s1      <= 1'b0;
         ack_s2      <= 1'b0;
         tx_data     <= '0;
         tx_oe       <= '0;
         tx_stb      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         ack_s1 <= tx_ack;
         ack_s2 <= ack_s1;

         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);

         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase

         // abort below is assigned later, so a same-cycle abort beats err_clr
         if (err_clr) timeout_err <= 1'b0;

         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data <= mem[rd_ptr];
                  tx_oe   <= 8'hFF;
                  cnt     <= SETUP_LD;
                  state   <= SETUP;
               end else begin
                  tx_oe <= 8'h00;
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  tx_stb <= 1'b1;
                  cnt    <= TMO_LD;
                  state  <= WAIT_HI;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            WAIT_HI: begin
               if (ack_s2) begin
                  tx_stb <= 1'b0;
                  cnt    <= TMO_LD;
                  state  <= WAIT_LO;
               end else if (cnt == '0) begin
                  tx_stb      <= 1'b0;
                  tx_oe       <= 8'h00;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            WAIT_LO: begin
               if (!ack_s2) begin
                  tx_oe <= 8'h00;
                  state <= IDLE;
               end else if (cnt == '0) begin
                  tx_stb      <= 1'b0;
                  tx_oe       <= 8'h00;
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uio_stream_tx.sv
// Self-checking bench for uio_stream_tx: directed handshake/timeout/reset
// scenarios plus a randomized producer against a queue-based reference.
`timescale 1ns/1ps
module tb_uio_stream_tx;

   localparam int DEPTH = 4;
   localparam int SETUP = 2;
   localparam int TMO   = 10;

   logic       clk;
   logic       rst;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [7:0] tx_data;
   logic [7:0] tx_oe;
   logic       tx_stb;
   logic       tx_ack;
   logic       busy;
   logic       timeout_err;
   logic       err_clr;
   logic [2:0] level;

   uio_stream_tx #(.DEPTH(DEPTH), .SETUP_CYCLES(SETUP), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .tx_data(tx_data), .tx_oe(tx_oe), .tx_stb(tx_stb),
      .tx_ack(tx_ack), .busy(busy), .timeout_err(timeout_err),
      .err_clr(err_clr), .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // reference: bytes accepted but not yet presented on the pins
   logic [7:0] model_q[$];
   int   cyc = 0;
   int   n_pushed = 0;
   int   completions = 0;
   int   oe_rise_cyc = 0;
   int   ack_set_cyc = 0;
   int   ack_clr_cyc = 0;
   int   hdelay = 0;
   logic host_auto = 1'b0;
   logic prev_stb = 1'b0;
   logic [7:0] prev_oe = 8'h00;
   logic [7:0] cur_byte = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      logic       acc;
      logic [7:0] d;
      logic [31:0] exp;
      acc = wr_valid && wr_ready && !rst;
      d   = wr_data;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
         model_q.push_back(d);
         n_pushed++;
      end
      if (tx_oe == 8'hFF && prev_oe != 8'hFF) begin
         exp = (model_q.size() != 0) ? {24'h0, model_q[0]} : 32'h1FF;
         chk("pop_order", 32'(tx_data), exp);
         if (model_q.size() != 0) void'(model_q.pop_front());
         cur_byte    = tx_data;
         oe_rise_cyc = cyc;
      end else if (tx_oe == 8'hFF && prev_oe == 8'hFF) begin
         chk("data_stable", 32'(tx_data), 32'(cur_byte));
      end
      if (tx_stb && !prev_stb) chk("stb_setup", 32'(cyc - oe_rise_cyc), 32'(SETUP + 1));
      if (!tx_stb && prev_stb && host_auto) chk("stb_fall", 32'(cyc), 32'(ack_set_cyc + 3));
      if (tx_oe == 8'h00 && prev_oe == 8'hFF && host_auto) begin
         chk("oe_fall", 32'(cyc), 32'(ack_clr_cyc + 3));
         completions++;
      end
      chk("level", 32'(level), 32'(model_q.size()));
      chk("wr_ready", 32'(wr_ready), 32'(model_q.size() != DEPTH));
      chk("busy", 32'(busy), 32'((tx_oe != 8'h00) || (model_q.size() != 0)));
      prev_stb = tx_stb;
      prev_oe  = tx_oe;
      if (host_auto) begin
         if (tx_stb && !tx_ack) begin
            if (hdelay == 0) begin
               tx_ack = 1'b1; ack_set_cyc = cyc; hdelay = int'($urandom_range(3, 0));
            end else hdelay--;
         end else if (!tx_stb && tx_ack) begin
            if (hdelay == 0) begin
               tx_ack = 1'b0; ack_clr_cyc = cyc; hdelay = int'($urandom_range(3, 0));
            end else hdelay--;
         end
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      wr_data  = b;
      wr_valid = 1'b1;
      for (int i = 0; i < 64 && !wr_ready; i++) tick();
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic wait_stb(input string tag, input logic val);
      for (int i = 0; i < 40 && tx_stb !== val; i++) tick();
      chk(tag, 32'(tx_stb), 32'(val));
   endtask

   task automatic wait_oe_low(input string tag);
      for (int i = 0; i < 40 && tx_oe !== 8'h00; i++) tick();
      chk(tag, 32'(tx_oe), 32'h00);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 400 && busy !== 1'b0; i++) tick();
      chk(tag, 32'(busy), 32'h0);
   endtask

   task automatic auto_on();
      hdelay    = 0;
      host_auto = 1'b1;
   endtask

   int c0;
   int p0;

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; tx_ack = 1'b0; err_clr = 1'b0;
      tick(); tick();
      chk("rst_oe", 32'(tx_oe), 32'h00);
      chk("rst_stb", 32'(tx_stb), 32'h0);
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_err", 32'(timeout_err), 32'h0);
      rst = 1'b0;
      tick();

      // single byte, manual host
      wr_data = 8'hA5; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      tick();
      chk("single_oe", 32'(tx_oe), 32'hFF);
      chk("single_data", 32'(tx_data), 32'hA5);
      tick(); chk("single_stb_e2", 32'(tx_stb), 32'h0);
      tick(); chk("single_stb_e3", 32'(tx_stb), 32'h0);
      tick(); chk("single_stb_e4", 32'(tx_stb), 32'h1);
      tick(); tick();
      tx_ack = 1'b1;
      tick(); chk("single_stb_hold1", 32'(tx_stb), 32'h1);
      tick(); chk("single_stb_hold2", 32'(tx_stb), 32'h1);
      tick(); chk("single_stb_fall", 32'(tx_stb), 32'h0);
      tick(); tick();
      tx_ack = 1'b0;
      tick(); chk("single_oe_hold1", 32'(tx_oe), 32'hFF);
      tick(); chk("single_oe_hold2", 32'(tx_oe), 32'hFF);
      tick(); chk("single_oe_rel", 32'(tx_oe), 32'h00);
      chk("single_data_kept", 32'(tx_data), 32'hA5);
      tick();

      // burst into a full FIFO behind a lead byte held in WAIT_HI
      c0 = completions;
      push_byte(8'h00);
      wait_stb("burst_lead_stb", 1'b1);
      for (int b = 1; b <= 4; b++) push_byte(8'(b));
      chk("burst_full_ready", 32'(wr_ready), 32'h0);
      wr_data = 8'h05; wr_valid = 1'b1;
      tick();
      chk("burst_held_level", 32'(level), 32'h4);
      auto_on();
      push_byte(8'h05);
      wait_idle("burst_idle");
      chk("burst_level0", 32'(level), 32'h0);
      chk("burst_count", 32'(completions - c0), 32'h6);
      host_auto = 1'b0;

      // simultaneous push/pop at level 2, crossing the pointer wrap
      push_byte(8'h10);
      wait_stb("simul_stb", 1'b1);
      push_byte(8'h11);
      push_byte(8'h12);
      tx_ack = 1'b1;
      wait_stb("simul_stb_fall", 1'b0);
      tx_ack = 1'b0;
      wait_oe_low("simul_oe_rel");
      chk("simul_level_pre", 32'(level), 32'h2);
      wr_data = 8'h13; wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      chk("simul_level", 32'(level), 32'h2);
      chk("simul_data", 32'(tx_data), 32'h11);
      auto_on();
      wait_idle("simul_idle");
      host_auto = 1'b0;

      // timeout in WAIT_HI, next byte still goes out
      push_byte(8'hEE);
      push_byte(8'h77);
      wait_stb("tmo_stb", 1'b1);
      for (int i = 1; i <= TMO; i++) tick();
      chk("tmo_stb_before", 32'(tx_stb), 32'h1);
      chk("tmo_err_before", 32'(timeout_err), 32'h0);
      tick();
      chk("tmo_stb_fall", 32'(tx_stb), 32'h0);
      chk("tmo_err_set", 32'(timeout_err), 32'h1);
      chk("tmo_oe_rel", 32'(tx_oe), 32'h00);
      c0 = completions;
      auto_on();
      wait_idle("tmo_idle");
      chk("tmo_next_sent", 32'(completions - c0), 32'h1);
      chk("tmo_err_sticky", 32'(timeout_err), 32'h1);
      host_auto = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("tmo_err_clr", 32'(timeout_err), 32'h0);

      // stuck-high ack: WAIT_HI passes at once, WAIT_LO times out
      tx_ack = 1'b1;
      tick(); tick(); tick();
      push_byte(8'h3C);
      wait_stb("stuck_stb", 1'b1);
      tick();
      chk("stuck_stb_fall", 32'(tx_stb), 32'h0);
      for (int i = 1; i <= TMO; i++) tick();
      chk("stuck_oe_hold", 32'(tx_oe), 32'hFF);
      chk("stuck_err_before", 32'(timeout_err), 32'h0);
      tick();
      chk("stuck_oe_rel", 32'(tx_oe), 32'h00);
      chk("stuck_err_set", 32'(timeout_err), 32'h1);
      tx_ack = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("stuck_err_clr", 32'(timeout_err), 32'h0);

      // randomized producer, responsive host with random latency
      c0 = completions;
      p0 = n_pushed;
      auto_on();
      for (int i = 0; i < 300; i++) begin
         wr_valid = 1'($urandom_range(1, 0));
         wr_data  = 8'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      wait_idle("rand_idle");
      chk("rand_all_sent", 32'(completions - c0), 32'(n_pushed - p0));
      chk("rand_no_err", 32'(timeout_err), 32'h0);
      host_auto = 1'b0;
      tick();

      // asynchronous reset mid-WAIT_HI with three bytes queued
      push_byte(8'hD0);
      wait_stb("rstmid_stb", 1'b1);
      push_byte(8'hD1);
      push_byte(8'hD2);
      push_byte(8'hD3);
      chk("rstmid_level_pre", 32'(level), 32'h3);
      rst = 1'b1;
      #1;
      model_q.delete();
      chk("rstmid_stb", 32'(tx_stb), 32'h0);
      chk("rstmid_oe", 32'(tx_oe), 32'h00);
      chk("rstmid_level", 32'(level), 32'h0);
      chk("rstmid_ready", 32'(wr_ready), 32'h1);
      chk("rstmid_busy", 32'(busy), 32'h0);
      tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("rstmid_quiet", 32'(tx_oe), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
